// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: base opcodes, immediate-format codes and the
// decoded bundle that travels from decode to execute.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;

    // Encoding is {out_valid, skid_valid} so the flags fall straight out of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } skid_state_t;

    typedef struct packed {
        logic       illegal;
        logic       upper;
        logic [2:0] imm_sel;
    } dec_class_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        illegal;
    } dec_bundle_t;

    // Classifies an opcode: immediate format, U-type flag and legality.
    function automatic dec_class_t decode_class(input logic [6:0] opcode);
        dec_class_t c;
        c.illegal = 1'b0;
        c.upper   = 1'b0;
        c.imm_sel = IMM_NONE;
        if (opcode[1:0] != 2'b11) begin
            c.illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: c.imm_sel = IMM_I;
                OPC_STORE:            c.imm_sel = IMM_S;
                OPC_BRANCH:           c.imm_sel = IMM_B;
                OPC_JAL:              c.imm_sel = IMM_J;
                OPC_LUI, OPC_AUIPC:   c.upper   = 1'b1;
                OPC_OP:               c.imm_sel = IMM_NONE;
                default:              c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/Immgen.sv
// Immediate generator: sign-extends the I/S/B/J immediate fields of an instruction.
import rv32i_pkg::*;

module Immgen (
    input  logic [2:0]  immType,
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[6:0];

    // Reassemble the scattered immediate bits for the selected format.
    always_comb begin
        imm = 32'd0;
        case (immType)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_decode_ctrl.sv
// rv32i decode stage: classifies the fetched instruction, builds its immediate
// and registers the bundle behind a valid/ready handshake with a 1-entry skid.
import rv32i_pkg::*;

module id_decode_ctrl #(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic             out_f7b5,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t state;
    skid_state_t state_nxt;
    dec_class_t  cls;
    dec_bundle_t new_bundle;
    dec_bundle_t out_q;
    dec_bundle_t skid_q;
    logic [31:0] gen_imm;
    logic        accept;
    logic        retire;
    logic        load_out_new;
    logic        load_out_skid;
    logic        load_skid;

    assign cls = decode_class(in_instr[6:0]);

    Immgen u_immgen (
        .immType (cls.imm_sel),
        .instr   (in_instr),
        .imm     (gen_imm)
    );

    // Assemble the decoded bundle for the instruction currently offered by fetch.
    always_comb begin
        new_bundle         = '0;
        new_bundle.pc      = in_pc;
        new_bundle.rs1     = in_instr[19:15];
        new_bundle.rs2     = in_instr[24:20];
        new_bundle.rd      = in_instr[11:7];
        new_bundle.opcode  = in_instr[6:0];
        new_bundle.funct3  = in_instr[14:12];
        new_bundle.f7b5    = in_instr[30];
        new_bundle.illegal = cls.illegal;
        if (cls.illegal) begin
            new_bundle.imm = 32'd0;
        end else if (cls.upper) begin
            new_bundle.imm = {in_instr[31:12], 12'd0};
        end else begin
            new_bundle.imm = gen_imm;
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_SKID);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Next-state and data-steering decisions; flush overrides every transfer.
    always_comb begin
        state_nxt     = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt    = ST_FULL;
                        load_out_new = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && retire) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_SKID;
                        load_skid = 1'b1;
                    end else if (retire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (retire) begin
                        state_nxt     = ST_FULL;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output and skid data registers; they hold whenever no load is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new) begin
                out_q <= new_bundle;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_bundle;
            end
        end
    end

    // Saturating count of cycles where execute back-pressures a valid bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_f7b5    = out_q.f7b5;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Directed bench for id_decode_ctrl with an in-order scoreboard of expected bundles.
module tb_id_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_f7b5;
    logic        out_illegal;
    logic [3:0]  stall_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        illegal;
    } exp_t;

    exp_t sbq[$];
    exp_t pendExp;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_decode_ctrl #(.CNT_W(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_f7b5    (out_f7b5),
        .out_illegal (out_illegal),
        .stall_cnt   (stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkHandshake(input string tag, input logic expValid, input logic expReady);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, expReady});
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] expImm, input logic expIllegal,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        pendExp.pc      = pc;
        pendExp.imm     = expImm;
        pendExp.rs1     = instr[19:15];
        pendExp.rs2     = instr[24:20];
        pendExp.rd      = instr[11:7];
        pendExp.opcode  = instr[6:0];
        pendExp.funct3  = instr[14:12];
        pendExp.f7b5    = instr[30];
        pendExp.illegal = expIllegal;
    endtask

    // Scores any retirement and records any acceptance, then advances one clock.
    task automatic tick();
        exp_t e;
        if (flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_bundle", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("pc", out_pc, e.pc);
                    checkOutput("imm", out_imm, e.imm);
                    checkOutput("rs1", 32'(out_rs1), 32'(e.rs1));
                    checkOutput("rs2", 32'(out_rs2), 32'(e.rs2));
                    checkOutput("rd", 32'(out_rd), 32'(e.rd));
                    checkOutput("opcode", 32'(out_opcode), 32'(e.opcode));
                    checkOutput("funct3", 32'(out_funct3), 32'(e.funct3));
                    checkOutput("f7b5", {31'd0, out_f7b5}, {31'd0, e.f7b5});
                    checkOutput("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(pendExp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #12;
        $display("[TB] reset state");
        checkHandshake("reset", 1'b0, 1'b1);
        checkOutput("reset_out_pc", out_pc, 32'd0);
        checkOutput("reset_out_imm", out_imm, 32'd0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] addi x1,x0,-1");
        applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        checkHandshake("addi_pre", 1'b0, 1'b1);
        tick();
        checkHandshake("addi_latency", 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("addi_done", 1'b0, 1'b1);

        $display("[TB] back-to-back sw/beq/lui at full throughput");
        applyStimulus(1'b1, 32'h00112623, 32'h0000_0200, 32'h0000_000C, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hFE000EE3, 32'h0000_0204, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        checkHandshake("thru_1", 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h12345037, 32'h0000_0208, 32'h1234_5000, 1'b0, 1'b1, 1'b0);
        checkHandshake("thru_2", 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("thru_done", 1'b0, 1'b1);
        checkOutput("thru_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("[TB] back-pressure with three instructions");
        applyStimulus(1'b1, 32'h00500113, 32'h0000_0300, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        tick();
        checkHandshake("bp_a", 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h00208233, 32'h0000_0304, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        checkHandshake("bp_b", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0040006F, 32'h0000_0308, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        tick();
        checkHandshake("bp_c1", 1'b1, 1'b0);
        tick();
        checkOutput("bp_hold_pc", out_pc, 32'h0000_0300);
        checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd3);
        applyStimulus(1'b1, 32'h0040006F, 32'h0000_0308, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("bp_release", 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("bp_done", 1'b0, 1'b1);
        checkOutput("bp_stall_final", 32'(stall_cnt), 32'd3);

        $display("[TB] flush while skid is occupied");
        applyStimulus(1'b1, 32'h00100093, 32'h0000_0400, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00200093, 32'h0000_0404, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        tick();
        checkHandshake("fl_skid", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 32'h0000_0408, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        checkHandshake("fl_pre", 1'b1, 1'b0);
        tick();
        checkHandshake("fl_post", 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkHandshake("fl_idle", 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00400093, 32'h0000_040C, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("fl_resume", 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();

        $display("[TB] illegal encodings");
        applyStimulus(1'b1, 32'h00000000, 32'h0000_0500, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000007F, 32'h0000_0504, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        checkHandshake("ill_1", 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0508, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        checkHandshake("ill_2", 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("ill_done", 1'b0, 1'b1);

        $display("[TB] asynchronous reset mid-stall");
        applyStimulus(1'b1, 32'h00600093, 32'h0000_0600, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkHandshake("arst", 1'b0, 1'b1);
        checkOutput("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        sbq.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] stall counter saturation");
        applyStimulus(1'b1, 32'h00700093, 32'h0000_0700, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("sat_mid", 32'(stall_cnt), 32'd10);
        repeat (10) tick();
        checkOutput("sat_full", 32'(stall_cnt), 32'd15);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkHandshake("sat_done", 1'b0, 1'b1);
        checkOutput("sat_hold", 32'(stall_cnt), 32'd15);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
